// File: rtl/iq_requantize.sv
// iq_requantize: round-half-up IQ requantizer, 2-stage AXI-Stream pipeline with clip counter.
// Define IQ_REQUANT_SAT_EN to saturate out-of-range results instead of wrapping.
module iq_requantize #(
  parameter int I_WIDTH   = 48,
  parameter int O_WIDTH   = 16,
  parameter int MAX_SHIFT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [I_WIDTH-1:0]     IQ_tdata,
  input  logic                   IQ_tvalid,
  output logic                   IQ_tready,
  input  logic                   IQ_tlast,
  input  logic [4:0]             shift,
  output logic [2*O_WIDTH-1:0]   out_tdata,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic                   out_tlast,
  output logic [1:0]             out_tuser,
  output logic [15:0]            ovf_cnt,
  input  logic                   ovf_clr
);
  localparam int W = I_WIDTH / 2;
  localparam logic [W:0] ONE = 1;
  localparam logic signed [W:0] HI = {{(W-O_WIDTH+2){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [W:0] LO = {{(W-O_WIDTH+2){1'b1}}, {(O_WIDTH-1){1'b0}}};
  // One extra bit of headroom keeps x + 2^(s-1) from overflowing since s < W.
  function automatic logic signed [W:0] rnd(input logic [W-1:0] x, input logic [4:0] s);
    logic signed [W:0] b;
    b = (s == 5'd0) ? '0 : ONE << (s - 5'd1);
    return ($signed({x[W-1], x}) + b) >>> s;
  endfunction
  function automatic logic [O_WIDTH:0] fit(input logic signed [W:0] r);
    logic c;
    logic [O_WIDTH-1:0] o;
    c = (r > HI) || (r < LO);
`ifdef IQ_REQUANT_SAT_EN
    o = (r > HI) ? HI[O_WIDTH-1:0] : (r < LO) ? LO[O_WIDTH-1:0] : r[O_WIDTH-1:0];
`else
    o = r[O_WIDTH-1:0];
`endif
    return {c, o};
  endfunction
  logic                   en;
  logic [4:0]             s;
  logic [O_WIDTH:0]       fi, fq;
  logic                   v1_q, v1_d, l1_q, l1_d;
  logic signed [W:0]      ri1_q, ri1_d, rq1_q, rq1_d;
  logic                   vo_q, vo_d, tl_q, tl_d;
  logic [2*O_WIDTH-1:0]   dat_q, dat_d;
  logic [1:0]             usr_q, usr_d;
  logic [15:0]            cnt_q, cnt_d;
  assign en        = !vo_q || out_tready;
  assign IQ_tready = en;
  assign s         = (shift > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : shift;
  assign fi        = fit(ri1_q);
  assign fq        = fit(rq1_q);
  always_comb begin
    v1_d  = en ? IQ_tvalid : v1_q;
    l1_d  = en ? IQ_tlast : l1_q;
    ri1_d = en ? rnd(IQ_tdata[I_WIDTH-1:W], s) : ri1_q;
    rq1_d = en ? rnd(IQ_tdata[W-1:0], s) : rq1_q;
    vo_d  = en ? v1_q : vo_q;
    tl_d  = en ? l1_q : tl_q;
    dat_d = en ? {fi[O_WIDTH-1:0], fq[O_WIDTH-1:0]} : dat_q;
    usr_d = en ? {fi[O_WIDTH], fq[O_WIDTH]} : usr_q;
    cnt_d = ovf_clr ? '0 :
            (en && v1_q && (fi[O_WIDTH] || fq[O_WIDTH]) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      l1_q  <= 1'b0;
      ri1_q <= '0;
      rq1_q <= '0;
      vo_q  <= 1'b0;
      tl_q  <= 1'b0;
      dat_q <= '0;
      usr_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      l1_q  <= l1_d;
      ri1_q <= ri1_d;
      rq1_q <= rq1_d;
      vo_q  <= vo_d;
      tl_q  <= tl_d;
      dat_q <= dat_d;
      usr_q <= usr_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_tdata  = dat_q;
  assign out_tvalid = vo_q;
  assign out_tlast  = tl_q;
  assign out_tuser  = usr_q;
  assign ovf_cnt    = cnt_q;
endmodule

// File: tb/tb_iq_requantize.sv
// tb_iq_requantize: randomized scoreboard bench for iq_requantize (default parameters).
module tb_iq_requantize;
  logic        clk = 0, rst = 1;
  logic [47:0] IQ_tdata = '0;
  logic        IQ_tvalid = 0, IQ_tlast = 0, IQ_tready;
  logic [4:0]  shift = '0;
  logic [31:0] out_tdata;
  logic        out_tvalid, out_tlast, out_tready = 1;
  logic [1:0]  out_tuser;
  logic [15:0] ovf_cnt;
  logic        ovf_clr = 0;
  typedef struct { longint i; longint q; int s; bit l; } beat_t;
  typedef struct { logic [31:0] d; logic [1:0] u; logic l; } exp_t;
  beat_t  stim_q[$];
  exp_t   exp_q[$];
  int     passed = 0, total = 0, popped_clips = 0;
  bit     chk_cnt = 1, stall_p = 0;
  longint hold_p = 0;
  always #5 clk = ~clk;
  iq_requantize dut (
    .clk(clk), .rst(rst), .IQ_tdata(IQ_tdata), .IQ_tvalid(IQ_tvalid), .IQ_tready(IQ_tready),
    .IQ_tlast(IQ_tlast), .shift(shift), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast), .out_tuser(out_tuser),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );
  task automatic chk(input string n, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", n, act, exp);
  endtask
  // Reference: round half up, floor divide, then saturate or wrap to 16 bits.
  function automatic longint model(input longint x, input int sh, output bit clip);
    longint s, v, p, r;
    s = (sh > 15) ? 15 : sh;
    p = longint'(1) << s;
    v = x + ((s > 0) ? p / 2 : 0);
    r = (v >= 0) ? v / p : -((-v + p - 1) / p);
    clip = (r > 32767) || (r < -32768);
`ifdef IQ_REQUANT_SAT_EN
    return clip ? ((r > 0) ? 32767 : -32768) : r;
`else
    return ((r % 65536) + 65536 + 32768) % 65536 - 32768;
`endif
  endfunction
  function automatic void push_exp(input beat_t b);
    bit ci, cq;
    longint ri, rq;
    exp_t e;
    ri = model(b.i, b.s, ci);
    rq = model(b.q, b.s, cq);
    e.d = {16'(ri), 16'(rq)};
    e.u = {ci, cq};
    e.l = b.l;
    exp_q.push_back(e);
  endfunction
  function automatic longint rnd24();
    logic [31:0] r;
    r = $urandom;
    return (r[31:30] == 2'd0) ? longint'($signed(r[15:0])) : longint'($signed(r[23:0]));
  endfunction
  task automatic add(input longint i, input longint q, input int s, input bit l);
    beat_t b;
    b.i = i; b.q = q; b.s = s; b.l = l;
    stim_q.push_back(b);
  endtask
  // mode 0: out_tready high; 1: random; 2: low for cycles 3..7
  task automatic drive(input int mode, input int vpct);
    int cyc = 0;
    while (stim_q.size() != 0 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      out_tready = (mode == 0) ? 1'b1 : (mode == 2) ? !(cyc >= 3 && cyc <= 7) : ($urandom_range(0, 99) < 70);
      IQ_tvalid  = $urandom_range(0, 99) < vpct;
      IQ_tdata   = {24'(stim_q[0].i), 24'(stim_q[0].q)};
      shift      = 5'(stim_q[0].s);
      IQ_tlast   = stim_q[0].l;
      @(negedge clk);
      if (IQ_tvalid && IQ_tready && !rst) begin
        push_exp(stim_q[0]);
        void'(stim_q.pop_front());
      end
    end
    chk("drive_timeout", stim_q.size(), 0);
    @(posedge clk); #1;
    IQ_tvalid = 0;
    IQ_tlast  = 0;
  endtask
  task automatic drain();
    int n = 0;
    out_tready = 1;
    while ((exp_q.size() != 0 || out_tvalid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask
  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic direct(input longint i, input longint q, input int s,
                        input longint ei, input longint eq, input logic [1:0] eu);
    add(i, q, s, 0);
    drive(0, 100);
    @(posedge clk);
    @(negedge clk);
    chk("dir_i", $signed(out_tdata[31:16]), ei);
    chk("dir_q", $signed(out_tdata[15:0]), eq);
    chk("dir_user", out_tuser, eu);
    drain();
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      popped_clips = 0;
      stall_p = 0;
    end else begin
      if (stall_p) chk("hold_stable", {out_tlast, out_tuser, out_tdata}, hold_p);
      stall_p = out_tvalid && !out_tready;
      hold_p  = {out_tlast, out_tuser, out_tdata};
      if (out_tvalid && !out_tready) chk("stall_tready", IQ_tready, 0);
      if (chk_cnt)
        chk("ovf_cnt", ovf_cnt, popped_clips + ((out_tvalid && exp_q.size() > 0 && exp_q[0].u != 2'b00) ? 1 : 0));
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", out_tvalid, 0);
        else begin
          e = exp_q.pop_front();
          chk("tdata", out_tdata, e.d);
          chk("tuser", out_tuser, e.u);
          chk("tlast", out_tlast, e.l);
          if (e.u != 2'b00) popped_clips++;
        end
      end
    end
  end
  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tdata", out_tdata, 0);
    chk("rst_tuser", out_tuser, 0);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_tready", IQ_tready, 1);
    direct(291, -291, 4, 18, -18, 2'b00);
`ifdef IQ_REQUANT_SAT_EN
    direct(40000, 5, 0, 32767, 5, 2'b10);
`else
    direct(40000, 5, 0, -25536, 5, 2'b10);
`endif
    chk("ovf_one", ovf_cnt, 1);
    direct(8388607, 0, 20, 256, 0, 2'b00);
    for (int n = 0; n < 300; n++) add(rnd24(), rnd24(), $urandom_range(0, 31), $urandom_range(0, 9) == 0);
    drive(1, 70);
    drain();
    for (int n = 1; n <= 10; n++) add(rnd24(), rnd24(), $urandom_range(0, 20), n == 10);
    drive(2, 100);
    drain();
    add(1000, -1000, 2, 0);
    add(-5000, 5000, 3, 1);
    drive(0, 100);
    do_reset();
    @(negedge clk);
    chk("midrst_tvalid", out_tvalid, 0);
    chk("midrst_ovf", ovf_cnt, 0);
    chk("midrst_tready", IQ_tready, 1);
    repeat (6) @(negedge clk);
    for (int n = 0; n < 5; n++) add(40000, 0, 0, 0);
    drive(0, 100);
    drain();
    chk("ovf_five", ovf_cnt, 5);
    chk_cnt = 0;
    add(-40000, 0, 0, 1);
    drive(0, 100);
    ovf_clr = 1;
    @(posedge clk); #1;
    ovf_clr = 0;
    @(negedge clk);
    chk("clr_priority", ovf_cnt, 0);
    chk("clr_user", out_tuser, 2'b10);
    drain();
    chk("ovf_after_clr", ovf_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
